otp_seq: RTL and testbench

OTP_SEQ -- requirements
Module: otp_seq

---
 rtl/otp_pkg.sv | 32 +++
 rtl/otp_timer.sv | 39 +++
 rtl/otp_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_otp_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// otp_pkg: shared definitions for the OTP read/program sequencer.
//   otp_state_e  - sequencer FSM states
//   TMR_W        - width of the phase timer
//   IDLE_*       - OTP macro control levels when no operation is running
//   otp_addr()   - packs {byte, bit} into the 6-bit OTP bit address
package otp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_WRITE,
        PG_SETUP,
        PG_FETCH,
        PG_BIT,
        PG_HOLD,
        DONE
    } otp_state_e;

    localparam int unsigned TMR_W = 16;

    localparam logic IDLE_CSB    = 1'b1;
    localparam logic IDLE_STROBE = 1'b0;
    localparam logic IDLE_LOAD   = 1'b0;
    localparam logic IDLE_PGENB  = 1'b1;
    localparam logic IDLE_VDDQSW = 1'b0;

    function automatic logic [5:0] otp_addr(input logic [2:0] byte_idx,
                                            input logic [2:0] bit_idx);
        return {byte_idx, bit_idx};
    endfunction

endpackage

// File: rtl/otp_timer.sv
// otp_timer: loadable down-counter used to time strobe and supply-settle phases.
//   sys_clk, rst - clock, synchronous active-high reset
//   i_load       - load i_val this cycle (takes priority over counting)
//   i_val        - value to load; a phase of N cycles loads N-1
//   o_zero       - counter has reached zero (phase ends this cycle)
module otp_timer
    import otp_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/otp_seq.sv
// otp_seq: OTP sequencer. A read copies NUM_BYTES OTP bytes into the register
// file at XBUS_BASE; a program burns the set bits of NUM_BYTES register-file
// bytes into the OTP, one strobe pulse per set bit.
//   sys_clk, rst                    - clock, synchronous active-high reset
//   i_otp_read_n (fall), i_otp_prog (rise) - operation requests
//   i_run_test_mode                 - program enable; dropping it aborts a program
//   xbus_addr/xbus_din/xbus_wr      - register-file write port, xbus_dout read data
//   o_otp_*                         - OTP macro controls and bit address, i_otp_q read data
//   o_busy, o_done, o_err           - status
module otp_seq
    import otp_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 8,
    parameter logic [6:0]  XBUS_BASE = 7'h10,
    parameter int unsigned T_RD      = 2,
    parameter int unsigned T_PGM     = 10,
    parameter int unsigned T_VDD     = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       i_otp_read_n,
    input  logic       i_otp_prog,
    input  logic       i_run_test_mode,
    output logic [6:0] xbus_addr,
    output logic [7:0] xbus_din,
    input  logic [7:0] xbus_dout,
    output logic       xbus_wr,
    output logic       o_otp_vddqsw,
    output logic       o_otp_csb,
    output logic       o_otp_strobe,
    output logic       o_otp_load,
    output logic       o_otp_pgenb,
    output logic [5:0] o_otp_addr,
    input  logic [7:0] i_otp_q,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [2:0]       LAST_BYTE = 3'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] LD_RD     = TMR_W'(T_RD - 1);
    localparam logic [TMR_W-1:0] LD_PGM    = TMR_W'(T_PGM - 1);
    localparam logic [TMR_W-1:0] LD_VDD    = TMR_W'(T_VDD - 1);

    otp_state_e       state_q, state_d;
    logic [2:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;     // read capture or program shift byte
    logic             gap_q, gap_d;       // strobe-low cycle after a programmed bit
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic             rdn_prev_q, rdn_prev_d;
    logic             prog_prev_q, prog_prev_d;
    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             rd_req, pg_req;
    logic             rd_mode, pg_mode, pg_abortable;

    otp_timer #(.W(TMR_W)) u_timer (
        .sys_clk (sys_clk),
        .rst     (rst),
        .i_load  (tmr_load),
        .i_val   (tmr_val),
        .o_zero  (tmr_zero)
    );

    assign rdn_prev_d  = i_otp_read_n;
    assign prog_prev_d = i_otp_prog;
    assign rd_req      = rdn_prev_q & ~i_otp_read_n;
    assign pg_req      = ~prog_prev_q & i_otp_prog;

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        bit_d        = bit_q;
        data_d       = data_q;
        gap_d        = gap_q;
        abort_d      = abort_q;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        o_otp_strobe = IDLE_STROBE;
        xbus_wr      = 1'b0;
        xbus_addr    = '0;
        xbus_din     = '0;
        o_done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d  = RD_STROBE;
                    byte_d   = '0;
                    bit_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RD;
                end else if (pg_req) begin
                    if (i_run_test_mode) begin
                        state_d  = PG_SETUP;
                        byte_d   = '0;
                        bit_d    = '0;
                        gap_d    = 1'b0;
                        abort_d  = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = LD_VDD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD_STROBE: begin
                o_otp_strobe = 1'b1;
                if (tmr_zero) begin
                    data_d  = i_otp_q;
                    state_d = RD_WRITE;
                end
            end
            RD_WRITE: begin
                xbus_wr   = 1'b1;
                xbus_addr = XBUS_BASE + {4'b0, byte_q};
                xbus_din  = data_q;
                if (byte_q == LAST_BYTE) begin
                    state_d = DONE;
                end else begin
                    byte_d   = byte_q + 3'd1;
                    state_d  = RD_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RD;
                end
            end
            PG_SETUP: begin
                if (tmr_zero) state_d = PG_FETCH;
            end
            PG_FETCH: begin
                xbus_addr = XBUS_BASE + {4'b0, byte_q};
                data_d    = xbus_dout;
                bit_d     = '0;
                gap_d     = 1'b0;
                state_d   = PG_BIT;
                tmr_load  = 1'b1;
                tmr_val   = LD_PGM;
            end
            PG_BIT: begin
                if (data_q[bit_q] && !gap_q) begin
                    o_otp_strobe = 1'b1;
                    if (tmr_zero) gap_d = 1'b1;
                end else begin
                    // Address only advances out of a strobe-low cycle, so the
                    // next bit never sees strobe high across an address change.
                    gap_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        if (byte_q == LAST_BYTE) begin
                            state_d  = PG_HOLD;
                            tmr_load = 1'b1;
                            tmr_val  = LD_VDD;
                        end else begin
                            byte_d  = byte_q + 3'd1;
                            state_d = PG_FETCH;
                        end
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        tmr_load = 1'b1;
                        tmr_val  = LD_PGM;
                    end
                end
            end
            PG_HOLD: begin
                if (tmr_zero) state_d = DONE;
            end
            DONE: begin
                o_done  = 1'b1;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Losing test mode kills the strobe combinationally and still
        // discharges vddqsw through a full hold phase.
        if (pg_abortable && !i_run_test_mode) begin
            o_otp_strobe = 1'b0;
            byte_d       = byte_q;
            bit_d        = bit_q;
            abort_d      = 1'b1;
            state_d      = PG_HOLD;
            tmr_load     = 1'b1;
            tmr_val      = LD_VDD;
        end
    end

    always_comb begin
        rd_mode      = (state_q == RD_STROBE) || (state_q == RD_WRITE);
        pg_mode      = (state_q == PG_SETUP) || (state_q == PG_FETCH) ||
                       (state_q == PG_BIT)   || (state_q == PG_HOLD);
        pg_abortable = (state_q == PG_SETUP) || (state_q == PG_FETCH) ||
                       (state_q == PG_BIT);
        o_otp_csb    = (rd_mode || pg_mode) ? 1'b0 : IDLE_CSB;
        o_otp_load   = rd_mode ? 1'b1 : IDLE_LOAD;
        o_otp_pgenb  = pg_mode ? 1'b0 : IDLE_PGENB;
        o_otp_vddqsw = pg_mode ? 1'b1 : IDLE_VDDQSW;
    end

    assign o_otp_addr = otp_addr(byte_q, bit_q);
    assign o_busy     = (state_q != IDLE);
    assign o_err      = err_q | ((state_q == DONE) & abort_q);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            gap_q       <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            // Track the live request levels so a level held through reset
            // is not mistaken for a fresh edge afterwards.
            rdn_prev_q  <= i_otp_read_n;
            prog_prev_q <= i_otp_prog;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            gap_q       <= gap_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            rdn_prev_q  <= rdn_prev_d;
            prog_prev_q <= prog_prev_d;
        end
    end

endmodule

// File: tb/tb_otp_seq.sv
// tb_otp_seq: scenario tasks for otp_seq. Expected register-file writes and
// strobe pulses are queued when a request is driven; tick() samples the DUT
// each negedge and queues what it saw; each task compares the two.
module tb_otp_seq;

    localparam int NB    = 8;
    localparam int T_RD  = 2;
    localparam int T_PGM = 10;
    localparam int T_VDD = 4;

    logic       sys_clk, rst, i_otp_read_n, i_otp_prog, i_run_test_mode;
    logic [6:0] xbus_addr;
    logic [7:0] xbus_din, xbus_dout, i_otp_q;
    logic       xbus_wr, o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb;
    logic [5:0] o_otp_addr;
    logic       o_busy, o_done, o_err;

    logic       q_var, dout_var;
    logic [7:0] q_fix, dout_fix;

    // OTP array model: fixed byte, or a per-byte pattern; register file model likewise.
    assign i_otp_q   = q_var ? (8'h30 ^ {5'b0, o_otp_addr[5:3]}) : q_fix;
    assign xbus_dout = dout_var ? (8'h81 ^ {1'b0, xbus_addr}) : dout_fix;

    otp_seq #(.NUM_BYTES(NB), .XBUS_BASE(7'h10), .T_RD(T_RD), .T_PGM(T_PGM), .T_VDD(T_VDD)) dut (
        .sys_clk(sys_clk), .rst(rst), .i_otp_read_n(i_otp_read_n), .i_otp_prog(i_otp_prog),
        .i_run_test_mode(i_run_test_mode), .xbus_addr(xbus_addr), .xbus_din(xbus_din),
        .xbus_dout(xbus_dout), .xbus_wr(xbus_wr), .o_otp_vddqsw(o_otp_vddqsw),
        .o_otp_csb(o_otp_csb), .o_otp_strobe(o_otp_strobe), .o_otp_load(o_otp_load),
        .o_otp_pgenb(o_otp_pgenb), .o_otp_addr(o_otp_addr), .i_otp_q(i_otp_q),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_wr[$], obs_wr[$];        // {addr, din}
    logic [13:0] exp_pulse[$], obs_pulse[$];  // {otp_addr, length}

    int cyc = 0;
    int stb_len, n_stb, n_glitch, first_stb, last_stb;
    int n_vdd, vdd_first, vdd_last, n_done, done_cyc, n_err, err_cyc, n_busy, n_csb;
    logic [5:0] stb_addr;
    logic [3:0] stb_mode;

    // {xbus_addr, xbus_din, wr, vddqsw, csb, strobe, load, pgenb, otp_addr, busy, done, err}
    logic [29:0] idle_vec;

    task automatic clear_obs();
        obs_wr.delete(); obs_pulse.delete(); exp_wr.delete(); exp_pulse.delete();
        stb_len = 0; n_stb = 0; n_glitch = 0; first_stb = -1; last_stb = -1;
        n_vdd = 0; vdd_first = -1; vdd_last = -1; n_done = 0; done_cyc = -1;
        n_err = 0; err_cyc = -1; n_busy = 0; n_csb = 0;
    endtask

    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        if (!rst) begin
            if (xbus_wr) obs_wr.push_back({xbus_addr, xbus_din});
            if (o_otp_strobe) begin
                if (stb_len == 0) begin
                    stb_addr = o_otp_addr;
                    stb_mode = {o_otp_csb, o_otp_load, o_otp_pgenb, o_otp_vddqsw};
                    n_stb++;
                    if (first_stb < 0) first_stb = cyc;
                end else if (o_otp_addr !== stb_addr ||
                             {o_otp_csb, o_otp_load, o_otp_pgenb, o_otp_vddqsw} !== stb_mode) begin
                    n_glitch++;
                end
                stb_len++;
                last_stb = cyc;
            end else if (stb_len != 0) begin
                obs_pulse.push_back({stb_addr, 8'(stb_len)});
                stb_len = 0;
            end
            if (o_otp_vddqsw) begin
                n_vdd++;
                if (vdd_first < 0) vdd_first = cyc;
                vdd_last = cyc;
            end
            if (o_done) begin n_done++; done_cyc = cyc; end
            if (o_err) begin n_err++; err_cyc = cyc; end
            if (o_busy) n_busy++;
            if (!o_otp_csb) n_csb++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_otp_read_n = 1'b1; i_otp_prog = 1'b0; i_run_test_mode = 1'b0;
        repeat (3) tick();
        checks++;
        if ({xbus_addr, xbus_din, xbus_wr, o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load,
             o_otp_pgenb, o_otp_addr, o_busy, o_done, o_err} !== idle_vec) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h",
                     {xbus_addr, xbus_din, xbus_wr, o_otp_vddqsw, o_otp_csb, o_otp_strobe,
                      o_otp_load, o_otp_pgenb, o_otp_addr, o_busy, o_done, o_err}, idle_vec);
        end
        rst = 1'b0;
        clear_obs();
        repeat (4) tick();
        checks++;
        if (n_busy + n_done + n_err != 0) begin
            errors++;
            $display("FAIL reset_quiet busy=%0d done=%0d err=%0d want 0", n_busy, n_done, n_err);
        end
    endtask

    task automatic test_read();
        logic [14:0] e, o;
        logic [13:0] pe, po;
        int k;
        for (int m = 0; m < 2; m++) begin
            clear_obs();
            q_var = (m == 1); q_fix = 8'hA5;
            for (int b = 0; b < NB; b++) begin
                exp_wr.push_back({7'(7'h10 + b), (m == 1) ? (8'h30 ^ 8'(b)) : 8'hA5});
                exp_pulse.push_back({3'(b), 3'b000, 8'(T_RD)});
            end
            i_otp_read_n = 1'b0;
            k = 0;
            while (n_done == 0 && k < 200) begin tick(); k++; end
            checks++;
            if (n_done == 0) begin errors++; $display("FAIL read_timeout mode=%0d no o_done", m); end
            repeat (3) tick();
            while (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                o = (obs_wr.size() != 0) ? obs_wr.pop_front() : 15'h7fff;
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL read_wr mode=%0d got addr=%h din=%h want addr=%h din=%h",
                             m, o[14:8], o[7:0], e[14:8], e[7:0]);
                end
            end
            while (exp_pulse.size() != 0) begin
                pe = exp_pulse.pop_front();
                po = (obs_pulse.size() != 0) ? obs_pulse.pop_front() : 14'h3fff;
                checks++;
                if (po !== pe) begin
                    errors++;
                    $display("FAIL read_strobe mode=%0d got addr=%h len=%0d want addr=%h len=%0d",
                             m, po[13:8], po[7:0], pe[13:8], pe[7:0]);
                end
            end
            checks++;
            if (obs_wr.size() + obs_pulse.size() != 0 || n_done != 1 || n_vdd != 0 || n_glitch != 0) begin
                errors++;
                $display("FAIL read_extra wr=%0d pulses=%0d done=%0d vdd=%0d glitch=%0d want 0,0,1,0,0",
                         obs_wr.size(), obs_pulse.size(), n_done, n_vdd, n_glitch);
            end
            checks++;
            if (n_busy != NB * (T_RD + 1) + 1) begin
                errors++;
                $display("FAIL read_cycles got=%0d want=%0d", n_busy, NB * (T_RD + 1) + 1);
            end
            i_otp_read_n = 1'b1;
            tick();
        end
        q_var = 1'b0;
    endtask

    task automatic test_program();
        logic [13:0] pe, po;
        logic [7:0] d;
        int k, exp_busy, lead, tail;
        for (int m = 0; m < 2; m++) begin
            clear_obs();
            dout_var = (m == 1); dout_fix = 8'h66;
            exp_busy = 2 * T_VDD + 1; lead = -1; tail = -1;
            // Per byte: 1 fetch cycle, 1 cycle per clear bit, T_PGM+1 per set bit.
            for (int b = 0; b < NB; b++) begin
                d = (m == 1) ? (8'h81 ^ {1'b0, 7'(7'h10 + b)}) : 8'h66;
                exp_busy += 1;
                for (int i = 0; i < 8; i++) begin
                    if (d[i]) begin
                        exp_pulse.push_back({3'(b), 3'(i), 8'(T_PGM)});
                        exp_busy += T_PGM + 1;
                        if (b == 0 && lead < 0) lead = T_VDD + 1 + i;
                        if (b == NB - 1) tail = 1 + (7 - i) + T_VDD;
                    end else begin
                        exp_busy += 1;
                    end
                end
            end
            i_run_test_mode = 1'b1;
            i_otp_prog = 1'b1;
            k = 0;
            while (n_done == 0 && k < 3000) begin tick(); k++; end
            checks++;
            if (n_done == 0) begin errors++; $display("FAIL prog_timeout mode=%0d no o_done", m); end
            tick();
            while (exp_pulse.size() != 0) begin
                pe = exp_pulse.pop_front();
                po = (obs_pulse.size() != 0) ? obs_pulse.pop_front() : 14'h3fff;
                checks++;
                if (po !== pe) begin
                    errors++;
                    $display("FAIL prog_strobe mode=%0d got addr=%h len=%0d want addr=%h len=%0d",
                             m, po[13:8], po[7:0], pe[13:8], pe[7:0]);
                end
            end
            checks++;
            if (obs_pulse.size() != 0 || obs_wr.size() != 0 || n_glitch != 0 || n_err != 0 || n_done != 1) begin
                errors++;
                $display("FAIL prog_extra pulses=%0d wr=%0d glitch=%0d err=%0d done=%0d want 0,0,0,0,1",
                         obs_pulse.size(), obs_wr.size(), n_glitch, n_err, n_done);
            end
            checks++;
            if (first_stb - vdd_first != lead || vdd_last - last_stb != tail) begin
                errors++;
                $display("FAIL prog_vdd_settle lead=%0d tail=%0d want %0d,%0d",
                         first_stb - vdd_first, vdd_last - last_stb, lead, tail);
            end
            checks++;
            if (n_busy != exp_busy || vdd_last != done_cyc - 1) begin
                errors++;
                $display("FAIL prog_cycles busy=%0d want=%0d vdd_last=%0d done=%0d",
                         n_busy, exp_busy, vdd_last, done_cyc);
            end
            i_otp_prog = 1'b0;
            tick();
        end
        dout_var = 1'b0;
    endtask

    task automatic test_refused();
        int c0;
        clear_obs();
        i_run_test_mode = 1'b0;
        i_otp_prog = 1'b1;
        c0 = cyc;
        repeat (6) tick();
        checks++;
        if (n_err != 1 || err_cyc != c0 + 1) begin
            errors++;
            $display("FAIL refused_err count=%0d at=%0d want 1 at %0d", n_err, err_cyc, c0 + 1);
        end
        checks++;
        if (n_busy + n_csb + n_vdd + n_stb + n_done != 0) begin
            errors++;
            $display("FAIL refused_activity busy=%0d csb_low=%0d vdd=%0d stb=%0d done=%0d want 0",
                     n_busy, n_csb, n_vdd, n_stb, n_done);
        end
        i_otp_prog = 1'b0;
        i_run_test_mode = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [14:0] e, o;
        int k;
        clear_obs();
        q_fix = 8'h5A; i_run_test_mode = 1'b1;
        for (int b = 0; b < NB; b++) exp_wr.push_back({7'(7'h10 + b), 8'h5A});
        i_otp_read_n = 1'b0;
        i_otp_prog = 1'b1;
        repeat (5) tick();
        // Fresh edges mid-operation must be dropped.
        i_otp_read_n = 1'b1; i_otp_prog = 1'b0;
        tick();
        i_otp_read_n = 1'b0; i_otp_prog = 1'b1;
        k = 0;
        while (n_done == 0 && k < 200) begin tick(); k++; end
        repeat (10) tick();
        while (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            o = (obs_wr.size() != 0) ? obs_wr.pop_front() : 15'h7fff;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simul_wr got addr=%h din=%h want addr=%h din=%h",
                         o[14:8], o[7:0], e[14:8], e[7:0]);
            end
        end
        checks++;
        if (n_done != 1 || n_vdd != 0 || obs_wr.size() != 0 || n_busy != NB * (T_RD + 1) + 1) begin
            errors++;
            $display("FAIL simul_single_read done=%0d vdd=%0d extra_wr=%0d busy=%0d want 1,0,0,%0d",
                     n_done, n_vdd, obs_wr.size(), n_busy, NB * (T_RD + 1) + 1);
        end
        i_otp_read_n = 1'b1; i_otp_prog = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_abort();
        int k, drop_cyc, stb_at_drop;
        clear_obs();
        dout_fix = 8'h66; i_run_test_mode = 1'b1;
        i_otp_prog = 1'b1;
        k = 0;
        while (!(o_otp_strobe && o_otp_addr[5:3] == 3'd2) && k < 1000) begin tick(); k++; end
        checks++;
        if (k >= 1000) begin errors++; $display("FAIL abort_timeout byte 2 strobe not seen"); end
        i_run_test_mode = 1'b0;
        #1;
        checks++;
        if (o_otp_strobe !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobe_drop got=%b want=0", o_otp_strobe);
        end
        drop_cyc = cyc;
        stb_at_drop = n_stb;
        k = 0;
        while (n_done == 0 && k < 50) begin tick(); k++; end
        checks++;
        if (done_cyc - drop_cyc != T_VDD + 1 || vdd_last != done_cyc - 1) begin
            errors++;
            $display("FAIL abort_hold done_after=%0d vdd_last=%0d want %0d,%0d",
                     done_cyc - drop_cyc, vdd_last, T_VDD + 1, done_cyc - 1);
        end
        checks++;
        if (n_err != 1 || err_cyc != done_cyc || n_stb != stb_at_drop) begin
            errors++;
            $display("FAIL abort_err err=%0d at=%0d done_at=%0d new_stb=%0d want 1 with done, 0 new",
                     n_err, err_cyc, done_cyc, n_stb - stb_at_drop);
        end
        i_otp_prog = 1'b0; i_run_test_mode = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int k;
        clear_obs();
        dout_fix = 8'h66; i_run_test_mode = 1'b1;
        i_otp_prog = 1'b1;
        k = 0;
        while (n_stb < 3 && k < 1000) begin tick(); k++; end
        checks++;
        if (n_stb < 3) begin errors++; $display("FAIL rstmid_timeout third strobe not seen"); end
        rst = 1'b1;
        i_otp_read_n = 1'b0;  // level change during reset must not start a read
        tick();
        checks++;
        if ({xbus_addr, xbus_din, xbus_wr, o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load,
             o_otp_pgenb, o_otp_addr, o_busy, o_done, o_err} !== idle_vec) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h want=%h",
                     {xbus_addr, xbus_din, xbus_wr, o_otp_vddqsw, o_otp_csb, o_otp_strobe,
                      o_otp_load, o_otp_pgenb, o_otp_addr, o_busy, o_done, o_err}, idle_vec);
        end
        rst = 1'b0;
        clear_obs();
        repeat (20) tick();
        checks++;
        if (n_done + n_busy + n_err + n_stb + n_vdd != 0) begin
            errors++;
            $display("FAIL rstmid_quiet done=%0d busy=%0d err=%0d stb=%0d vdd=%0d want 0",
                     n_done, n_busy, n_err, n_stb, n_vdd);
        end
        i_otp_read_n = 1'b1; i_otp_prog = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        idle_vec = {7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0};
        q_var = 1'b0; dout_var = 1'b0; q_fix = 8'h00; dout_fix = 8'h00;
        rst = 1'b1; i_otp_read_n = 1'b1; i_otp_prog = 1'b0; i_run_test_mode = 1'b0;
        clear_obs();
        test_reset();
        test_read();
        test_program();
        test_refused();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
